// File: rtl/sd_bmp_loader_pkg.sv
// Shared definitions for the SD-card bitmap loader.
// Holds the loader FSM state encodings, sector geometry, the default
// per-image sector stride (also used by the command decoder) and the
// sector address helper.
package sd_bmp_loader_pkg;

    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned DATA_W              = 16;
    localparam int unsigned SECTOR_BYTES        = 512;
    localparam int unsigned WORD_BYTES          = DATA_W / 8;
    localparam int unsigned DEF_WORDS_PER_SEC   = SECTOR_BYTES / WORD_BYTES;
    localparam int unsigned DEF_SECTORS_PER_IMG = 1800;

    // Loader FSM states, 3-bit encodings
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Sector address of sector idx within an image; wraps modulo 2^32
    function automatic logic [ADDR_W-1:0] sec_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/sd_req_retry.sv
// SD read request helper: owns the sd_rd_start pulse, the busy-rise timeout
// and the per-sector retry count, and reports the outcome to the loader FSM.
// Ports:
//   issue       - loader is in ISSUE; pulse sd_rd_start next cycle
//   waiting     - loader is in WAIT_HI; timeout counter runs
//   clear       - zero the retry count (new image or new sector)
//   sd_rd_busy  - SD core busy
//   sd_rd_start - registered one-cycle request to the SD core
//   ok_c        - busy seen while waiting
//   retry_c     - timeout, reissue the same sector
//   fail_c      - timeout, retries exhausted
module sd_req_retry #(
    parameter int unsigned BUSY_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic waiting,
    input  logic clear,
    input  logic sd_rd_busy,
    output logic sd_rd_start,
    output logic ok_c,
    output logic retry_c,
    output logic fail_c
);

    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    logic [TMR_W-1:0] tmr;
    logic [RTY_W-1:0] retry_cnt;
    logic             timeout_c;
    logic             last_try_c;

    // Timer reads 0 in the cycle sd_rd_start is high, so busy may rise in
    // any of the first BUSY_TIMEOUT WAIT_HI cycles; busy wins over timeout.
    assign ok_c       = waiting && sd_rd_busy;
    assign timeout_c  = waiting && !sd_rd_busy && (tmr == TMR_W'(BUSY_TIMEOUT - 1));
    assign last_try_c = (32'(retry_cnt) + 32'd1) >= MAX_RETRY;
    assign retry_c    = timeout_c && !last_try_c;
    assign fail_c     = timeout_c && last_try_c;

    // Request pulse, timeout counter and retry counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_rd_start <= 1'b0;
            tmr         <= '0;
            retry_cnt   <= '0;
        end else begin
            sd_rd_start <= issue;
            if (issue) begin
                tmr <= '0;
            end else if (waiting && (tmr != TMR_W'(BUSY_TIMEOUT - 1))) begin
                tmr <= tmr + TMR_W'(1);
            end
            if (clear) begin
                retry_cnt <= '0;
            end else if (timeout_c) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
            end
        end
    end

endmodule

// File: rtl/sd_bmp_loader.sv
// SD-card bitmap loader: on each new image request reads SECTORS_PER_IMG
// consecutive sectors through the SD read core and streams the 16-bit words
// into the SDRAM write FIFO, pulsing write_finish when the image is complete.
// Ports:
//   sd_card_bmp_read_addr - first sector of requested image (0 = none)
//   sd_rd_start/sec_addr  - request to SD read core
//   sd_rd_busy/val_en/val_data - SD read core status and data
//   wr_load               - image start, clears SDRAM write pointer
//   wr_en/wr_data         - SDRAM write-FIFO port
//   write_finish          - whole image written
//   load_err              - sticky error, cleared by next accepted request
//   busy                  - loader not idle
module sd_bmp_loader
    import sd_bmp_loader_pkg::*;
#(
    parameter int unsigned SECTORS_PER_IMG = DEF_SECTORS_PER_IMG,
    parameter int unsigned WORDS_PER_SEC   = DEF_WORDS_PER_SEC,
    parameter int unsigned BUSY_TIMEOUT    = 1024,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] sd_card_bmp_read_addr,
    output logic              sd_rd_start,
    output logic [ADDR_W-1:0] sd_rd_sec_addr,
    input  logic              sd_rd_busy,
    input  logic              sd_rd_val_en,
    input  logic [DATA_W-1:0] sd_rd_val_data,
    output logic              wr_load,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              write_finish,
    output logic              load_err,
    output logic              busy
);

    localparam int unsigned SEC_W = $clog2(SECTORS_PER_IMG + 1);
    // One extra code so an over-long sector saturates above WORDS_PER_SEC
    localparam int unsigned WRD_W = $clog2(WORDS_PER_SEC + 2);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] base;
    logic              pending;
    logic [SEC_W-1:0]  sec_cnt;
    logic [WRD_W-1:0]  word_cnt;

    logic              req_c;
    logic              start_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              ok_c;
    logic              retry_c;
    logic              fail_c;

    // A request is a new nonzero address; a direct request beats a pending one
    assign req_c      = (addr_q != '0) && (addr_q != last_addr);
    assign start_c    = (state == ST_IDLE) && (req_c || pending);
    assign sel_addr_c = req_c ? addr_q : pend_addr;

    sd_req_retry #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) u_req (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (state == ST_ISSUE),
        .waiting     (state == ST_WAIT_HI),
        .clear       (start_c || (state == ST_NEXT)),
        .sd_rd_busy  (sd_rd_busy),
        .sd_rd_start (sd_rd_start),
        .ok_c        (ok_c),
        .retry_c     (retry_c),
        .fail_c      (fail_c)
    );

    // Request tracking, loader FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            last_addr      <= '0;
            pend_addr      <= '0;
            base           <= '0;
            pending        <= 1'b0;
            sec_cnt        <= '0;
            word_cnt       <= '0;
            sd_rd_sec_addr <= '0;
            wr_load        <= 1'b0;
            wr_en          <= 1'b0;
            wr_data        <= '0;
            write_finish   <= 1'b0;
            load_err       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            addr_q       <= sd_card_bmp_read_addr;
            wr_load      <= 1'b0;
            wr_en        <= 1'b0;
            write_finish <= 1'b0;

            // Zero address re-arms the same image for a later request
            if (addr_q == '0) begin
                last_addr <= '0;
            end
            // Newest request while busy preempts at the next sector boundary
            if ((state != ST_IDLE) && req_c) begin
                pending   <= 1'b1;
                pend_addr <= addr_q;
            end

            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        base      <= sel_addr_c;
                        last_addr <= sel_addr_c;
                        pending   <= 1'b0;
                        load_err  <= 1'b0;
                        sec_cnt   <= '0;
                        word_cnt  <= '0;
                        wr_load   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    sd_rd_sec_addr <= sec_addr(base, 32'(sec_cnt));
                    state          <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (ok_c) begin
                        state <= ST_WAIT_LO;
                    end else if (retry_c) begin
                        state <= ST_ISSUE;
                    end else if (fail_c) begin
                        load_err <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_WAIT_LO: begin
                    if (sd_rd_val_en) begin
                        if (word_cnt < WRD_W'(WORDS_PER_SEC)) begin
                            wr_en   <= 1'b1;
                            wr_data <= sd_rd_val_data;
                        end
                        if (word_cnt <= WRD_W'(WORDS_PER_SEC)) begin
                            word_cnt <= word_cnt + WRD_W'(1);
                        end
                    end
                    if (!sd_rd_busy) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (word_cnt != WRD_W'(WORDS_PER_SEC)) begin
                        load_err <= 1'b1;
                    end
                    sec_cnt  <= sec_cnt + SEC_W'(1);
                    word_cnt <= '0;
                    if (pending) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if ((sec_cnt + SEC_W'(1)) == SEC_W'(SECTORS_PER_IMG)) begin
                        write_finish <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_bmp_loader.sv
// Self-checking bench for sd_bmp_loader with a two-sector image.
// A behavioural SD core answers each sd_rd_start with random delays, gaps
// and data; the expected SDRAM write stream, sector addresses, pulses and
// error flag are derived from the loader's rules and compared on negedge.
module tb_sd_bmp_loader;

    localparam int unsigned SPI = 2;
    localparam int unsigned WPS = 256;
    localparam int unsigned TO  = 64;
    localparam int unsigned MR  = 3;
    localparam int START_BUDGET = 200;

    typedef struct {
        logic [15:0] d;
        int unsigned c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sd_card_bmp_read_addr;
    logic        sd_rd_start;
    logic [31:0] sd_rd_sec_addr;
    logic        sd_rd_busy;
    logic        sd_rd_val_en;
    logic [15:0] sd_rd_val_data;
    logic        wr_load;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        write_finish;
    logic        load_err;
    logic        busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned cnt_load = 0;
    int unsigned cnt_fin  = 0;
    int unsigned cnt_wr   = 0;
    logic [31:0] issue_a[$];
    int unsigned issue_c[$];
    exp_t        exp_q[$];

    sd_bmp_loader #(
        .SECTORS_PER_IMG (SPI),
        .WORDS_PER_SEC   (WPS),
        .BUSY_TIMEOUT    (TO),
        .MAX_RETRY       (MR)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sd_card_bmp_read_addr (sd_card_bmp_read_addr),
        .sd_rd_start           (sd_rd_start),
        .sd_rd_sec_addr        (sd_rd_sec_addr),
        .sd_rd_busy            (sd_rd_busy),
        .sd_rd_val_en          (sd_rd_val_en),
        .sd_rd_val_data        (sd_rd_val_data),
        .wr_load               (wr_load),
        .wr_en                 (wr_en),
        .wr_data               (wr_data),
        .write_finish          (write_finish),
        .load_err              (load_err),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor: tallies pulses, logs requests, checks the write stream
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_load) cnt_load++;
                if (write_finish) cnt_fin++;
                if (sd_rd_start) begin
                    issue_a.push_back(sd_rd_sec_addr);
                    issue_c.push_back(cyc);
                end
                if (wr_en) begin
                    cnt_wr++;
                    if (exp_q.size() == 0) begin
                        chk("wr_unexp", 32'(wr_en), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_data", 32'(wr_data), 32'(e.d));
                        chk("wr_lat", cyc, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_tally();
        cnt_load = 0;
        cnt_fin  = 0;
        cnt_wr   = 0;
        issue_a.delete();
        issue_c.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".start"}, 32'(sd_rd_start), 32'd0);
        chk({tag, ".sec"}, sd_rd_sec_addr, 32'd0);
        chk({tag, ".load"}, 32'(wr_load), 32'd0);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ".wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ".fin"}, 32'(write_finish), 32'd0);
        chk({tag, ".err"}, 32'(load_err), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        chk("idle", 32'(busy), 32'd0);
    endtask

    // Behavioural SD core for one sector: waits for a request, raises busy
    // after dly cycles, sends nw words with random gaps, then drops busy.
    task automatic sd_sector(input int nw, input bit incr, input int dly,
                             input logic [31:0] mid_addr, input int rst_at,
                             output bit seen);
        logic [15:0] w;
        seen = 1'b0;
        for (int n = 0; n < START_BUDGET && !seen; n++) begin
            @(negedge clk);
            seen = sd_rd_start;
        end
        chk("start_seen", 32'(seen), 32'd1);
        if (!seen) return;
        repeat (dly) @(negedge clk);
        sd_rd_busy = 1'b1;
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                sd_rd_val_en   = 1'b0;
                sd_rd_val_data = 16'($urandom);
            end
            @(negedge clk);
            if (i == rst_at) begin
                #2;
                rst_n                 = 1'b0;
                sd_rd_busy            = 1'b0;
                sd_rd_val_en          = 1'b0;
                sd_card_bmp_read_addr = '0;
                #1;
                check_all_zero("rst_mid");
                exp_q.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mid_addr != 32'd0 && i == nw / 2) sd_card_bmp_read_addr = mid_addr;
            w = incr ? 16'(i) : 16'($urandom);
            sd_rd_val_en   = 1'b1;
            sd_rd_val_data = w;
            if (i < int'(WPS)) exp_q.push_back('{d: w, c: cyc + 1});
        end
        @(negedge clk);
        sd_rd_val_en = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sd_rd_busy = 1'b0;
    endtask

    // Full image: expected writes are the first WPS words of each sector
    task automatic run_image(input string tag, input logic [31:0] a,
                             input int nw0, input int nw1, input bit incr, input int dly1);
        bit seen;
        int nexp;
        clear_tally();
        @(negedge clk);
        sd_card_bmp_read_addr = a;
        sd_sector(nw0, incr, int'($urandom_range(0, 6)), 32'd0, -1, seen);
        if (seen) sd_sector(nw1, incr, dly1, 32'd0, -1, seen);
        wait_idle();
        nexp = (nw0 < int'(WPS) ? nw0 : int'(WPS)) + (nw1 < int'(WPS) ? nw1 : int'(WPS));
        chk({tag, ".loads"}, cnt_load, 32'd1);
        chk({tag, ".fin"}, cnt_fin, 32'd1);
        chk({tag, ".nwr"}, cnt_wr, 32'(nexp));
        chk({tag, ".nissue"}, 32'(issue_a.size()), 32'(SPI));
        if (issue_a.size() == SPI) begin
            chk({tag, ".sec0"}, issue_a[0], a);
            chk({tag, ".sec1"}, issue_a[1], a + 32'd1);
        end
        chk({tag, ".err"}, 32'(load_err), 32'((nw0 != int'(WPS)) || (nw1 != int'(WPS))));
        chk({tag, ".left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit          seen;
        int          nw[2];
        int          r;
        logic [31:0] a;

        rst_n                 = 1'b0;
        sd_card_bmp_read_addr = '0;
        sd_rd_busy            = 1'b0;
        sd_rd_val_en          = 1'b0;
        sd_rd_val_data        = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal load, incrementing data, busy rising in the last allowed cycle
        run_image("norm", 32'h0000_2124, 256, 256, 1'b1, int'(TO) - 1);

        // Same address held: no reload; stray valid while idle is ignored
        clear_tally();
        @(negedge clk);
        sd_rd_val_en   = 1'b1;
        sd_rd_val_data = 16'hBEEF;
        @(negedge clk);
        sd_rd_val_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("dup.loads", cnt_load, 32'd0);
        chk("dup.busy", 32'(busy), 32'd0);
        chk("dup.nwr", cnt_wr, 32'd0);
        chk("dup.nissue", 32'(issue_a.size()), 32'd0);
        @(negedge clk);
        sd_card_bmp_read_addr = '0;
        repeat (4) @(negedge clk);
        run_image("reload", 32'h0000_2124, 256, 256, 1'b0, int'($urandom_range(0, 8)));

        // Sector address wraps modulo 2^32
        run_image("wrap", 32'hFFFF_FFFF, 256, 256, 1'b0, int'($urandom_range(0, 8)));

        // Short first sector: error, image still completes
        run_image("short", 32'h0000_5000, 200, 256, 1'b0, int'($urandom_range(0, 8)));

        // Random images with occasional short or long sectors
        for (int k = 0; k < 3; k++) begin
            a = $urandom | 32'h1;
            for (int s = 0; s < 2; s++) begin
                r = int'($urandom_range(0, 5));
                nw[s] = (r == 0) ? int'($urandom_range(1, 255)) :
                        (r == 1) ? int'($urandom_range(257, 259)) : 256;
            end
            run_image("rand", a, nw[0], nw[1], 1'b0, int'($urandom_range(0, TO - 1)));
        end

        // SD core never raises busy: MR requests, TO+1 apart, then error
        clear_tally();
        @(negedge clk);
        sd_card_bmp_read_addr = 32'h0000_3A5C;
        repeat (3 * (TO + 1) + 40) @(negedge clk);
        chk("to.nissue", 32'(issue_a.size()), 32'(MR));
        for (int i = 0; i < issue_a.size(); i++) chk("to.addr", issue_a[i], 32'h0000_3A5C);
        for (int i = 1; i < issue_c.size(); i++) chk("to.gap", issue_c[i] - issue_c[i-1], TO + 1);
        chk("to.err", 32'(load_err), 32'd1);
        chk("to.busy", 32'(busy), 32'd0);
        chk("to.fin", cnt_fin, 32'd0);
        chk("to.loads", cnt_load, 32'd1);
        repeat (2 * TO) @(negedge clk);
        chk("to.nomore", 32'(issue_a.size()), 32'(MR));

        // Preempt during sector 0: sector completes, image abandoned, reload
        clear_tally();
        @(negedge clk);
        sd_card_bmp_read_addr = 32'h0000_2124;
        sd_sector(256, 1'b1, 2, 32'h0000_29DC, -1, seen);
        if (seen) sd_sector(256, 1'b0, 3, 32'd0, -1, seen);
        chk("pre.nofin", cnt_fin, 32'd0);
        if (seen) sd_sector(256, 1'b0, 1, 32'd0, -1, seen);
        wait_idle();
        chk("pre.loads", cnt_load, 32'd2);
        chk("pre.fin", cnt_fin, 32'd1);
        chk("pre.nwr", cnt_wr, 32'd768);
        chk("pre.nissue", 32'(issue_a.size()), 32'd3);
        if (issue_a.size() == 3) begin
            chk("pre.sec0", issue_a[0], 32'h0000_2124);
            chk("pre.sec1", issue_a[1], 32'h0000_29DC);
            chk("pre.sec2", issue_a[2], 32'h0000_29DD);
        end
        chk("pre.err", 32'(load_err), 32'd0);

        // Asynchronous reset in the middle of a sector
        clear_tally();
        @(negedge clk);
        sd_card_bmp_read_addr = 32'h0000_7777;
        sd_sector(256, 1'b1, 1, 32'd0, 100, seen);
        repeat (5) @(negedge clk);
        check_all_zero("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
